// File: rtl/read_burst_sequencer.sv
// Arbitrates two byte-granular load requesters and turns each request into one
// aligned memory read burst, framing the returning beats for the read aligner.
module read_burst_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  localparam int B      = DATA_WIDTH / 8,
  localparam int SW     = $clog2(B),
  localparam int BEAT_W = LEN_WIDTH - SW + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0][LEN_WIDTH-1:0]  req_bytes_i,
  output logic                       mem_ar_valid_o,
  input  logic                       mem_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]      mem_ar_addr_o,
  output logic [BEAT_W-1:0]          mem_ar_len_o,
  input  logic                       mem_r_valid_i,
  output logic                       mem_r_ready_o,
  input  logic [DATA_WIDTH-1:0]      mem_r_data_i,
  output logic                       al_valid_o,
  output logic                       al_start_o,
  output logic                       al_end_o,
  output logic [DATA_WIDTH-1:0]      al_data_o,
  output logic [SW-1:0]              al_shamt_o,
  input  logic                       al_idle_i,
  output logic                       grant_id_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    ptr_q;
  logic                    grant_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [BEAT_W-1:0]       len_q, len_d;
  logic [SW-1:0]           shamt_q;
  logic [BEAT_W-1:0]       cnt_q, cnt_d;

  logic                    grant_vld_s;
  logic                    grant_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [LEN_WIDTH-1:0]    sel_bytes_s;
  logic [LEN_WIDTH+1:0]    sum_s;
  logic [BEAT_W:0]         beats_s;
  logic                    last_beat_s;

  // Round-robin winner: on contention the pointer decides.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = 1'b0;
    if (req_valid_i[0] && req_valid_i[1]) begin
      grant_vld_s = 1'b1;
      grant_s     = ptr_q;
    end else if (req_valid_i[0]) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b0;
    end else if (req_valid_i[1]) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_s     = 1'b0;
    end
  end

  // Beat count is ceil((off + bytes) / B), wide enough that it cannot overflow.
  assign accept_s    = (state_q == S_IDLE) && grant_vld_s && !rst_i;
  assign sel_addr_s  = req_addr_i[grant_s];
  assign sel_bytes_s = req_bytes_i[grant_s];
  assign sum_s       = {2'b00, sel_bytes_s}
                     + {{(LEN_WIDTH + 2 - SW){1'b0}}, sel_addr_s[SW-1:0]}
                     + (LEN_WIDTH + 2)'(B - 1);
  assign beats_s     = (BEAT_W + 1)'(sum_s >> SW);
  assign len_d       = BEAT_W'(beats_s - (BEAT_W + 1)'(1));
  assign last_beat_s = (cnt_q == len_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (sel_bytes_s != {LEN_WIDTH{1'b0}})) state_d = S_ADDR;
        else                                                 state_d = S_IDLE;
      end
      S_ADDR: begin
        if (mem_ar_ready_i) state_d = S_DATA;
        else                state_d = S_ADDR;
      end
      S_DATA: begin
        if (mem_r_valid_i && last_beat_s) state_d = S_DRAIN;
        else                              state_d = S_DATA;
      end
      S_DRAIN: begin
        if (al_idle_i) state_d = S_IDLE;
        else           state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ADDR && mem_ar_ready_i) begin
      cnt_d = {BEAT_W{1'b0}};
    end else if (state_q == S_DATA && mem_r_valid_i) begin
      cnt_d = cnt_q + BEAT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= 1'b0;
      grant_q   <= 1'b0;
      ar_addr_q <= {ADDR_WIDTH{1'b0}};
      len_q     <= {BEAT_W{1'b0}};
      shamt_q   <= {SW{1'b0}};
      cnt_q     <= {BEAT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      if (accept_s) begin
        ptr_q     <= ~grant_s;
        grant_q   <= grant_s;
        ar_addr_q <= {sel_addr_s[ADDR_WIDTH-1:SW], {SW{1'b0}}};
        len_q     <= len_d;
        shamt_q   <= sel_addr_s[SW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o    = 2'b00;
    mem_ar_valid_o = 1'b0;
    mem_r_ready_o  = 1'b0;
    al_valid_o     = 1'b0;
    al_start_o     = 1'b0;
    al_end_o       = 1'b0;
    al_data_o      = {DATA_WIDTH{1'b0}};
    busy_o         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept_s) req_ready_o = grant_s ? 2'b10 : 2'b01;
        else          req_ready_o = 2'b00;
      end
      S_ADDR: mem_ar_valid_o = 1'b1;
      S_DATA: begin
        mem_r_ready_o = 1'b1;
        al_valid_o    = mem_r_valid_i;
        al_start_o    = mem_r_valid_i && (cnt_q == {BEAT_W{1'b0}});
        al_end_o      = mem_r_valid_i && last_beat_s;
        al_data_o     = mem_r_data_i;
      end
      S_DRAIN: busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  assign mem_ar_addr_o = ar_addr_q;
  assign mem_ar_len_o  = len_q;
  assign al_shamt_o    = shamt_q;
  assign grant_id_o    = grant_q;

endmodule

// File: doc/read_burst_sequencer.md
# read_burst_sequencer

Controller that feeds the read burst aligner for vector loads. It arbitrates between two byte-granular load requesters and converts each request into one aligned memory read burst. It then forwards the returning beats to the aligner with start/end framing and the byte shift amount, and holds off the next request until the aligner reports idle. It sits between the load units and the memory read port, directly upstream of the aligner.

## Interface
- DATA_WIDTH, 64: memory/aligner beat width in bits; B = DATA_WIDTH/8 bytes per beat, SW = $clog2(B).
- ADDR_WIDTH, 32: byte address width.
- LEN_WIDTH, 8: request byte-count width; BEAT_W = LEN_WIDTH - SW + 1.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid (index 0, 1).
- req_ready  out  2  per-requester accept, one-hot or zero.
- req_addr  in  2×ADDR_WIDTH  start byte address per requester.
- req_bytes  in  2×LEN_WIDTH  byte count per requester; 0 is legal.
- mem_ar_valid / mem_ar_ready  out / in  1 / 1  burst address handshake.
- mem_ar_addr  out  ADDR_WIDTH  burst address, aligned down to B.
- mem_ar_len  out  BEAT_W  number of beats minus one.
- mem_r_valid / mem_r_ready  in / out  1 / 1  read data handshake.
- mem_r_data  in  DATA_WIDTH  read beat.
- al_valid, al_start, al_end  out  1 each  aligner framing (aligner i_valid/i_start/i_end).
- al_data  out  DATA_WIDTH  aligner i_data.
- al_shamt  out  SW  aligner i_shamt (byte offset).
- al_idle  in  1  aligner o_idle.
- grant_id  out  1  requester owning the current burst.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - Round-robin arbitration among asserted req_valid. The pointer prefers the requester not granted last; after reset it prefers req0.
  - req_ready[g] is driven high combinationally for the winner only; the request is accepted that cycle.
  - On accept, latch addr, bytes and grant_id, and update the RR pointer.
  - If bytes == 0: stay in IDLE with no memory traffic. Otherwise go to ADDR.
- Arithmetic:
  - off = addr[SW-1:0].
  - beats = ceil((off + bytes) / B), computed at BEAT_W+1 bits with no overflow.
  - mem_ar_addr = addr with the low SW bits cleared.
  - mem_ar_len = beats - 1.
  - al_shamt = off, held constant for the whole burst.
- ADDR:
  - mem_ar_valid = 1. Address and length stay stable until mem_ar_ready.
  - On handshake, go to DATA and clear the beat counter.
- DATA:
  - mem_r_ready = 1; the aligner has no backpressure.
  - Passthrough is combinational: al_valid = mem_r_valid, al_data = mem_r_data.
  - al_start = mem_r_valid && counter == 0.
  - al_end = mem_r_valid && counter == beats-1.
  - The counter advances only on mem_r_valid. After the end beat, go to DRAIN.
  - A single-beat burst asserts start and end together.
- DRAIN: when al_idle = 1, go to IDLE. req_ready stays 0 until the state is IDLE.
- mem_r_ready is 0 outside DATA; al_valid, al_start and al_end are 0 outside DATA.
- Only one burst is outstanding at a time.

## Timing
- Reset values: state IDLE, RR pointer preferring req0, beat counter 0, mem_ar_valid 0, mem_r_ready 0, al_* 0, grant_id 0, busy 0.
  - req_ready may assert in the first cycle after reset if req_valid is high.
- Minimum latency: accept (cycle 0) → mem_ar_valid (cycle 1). With immediate mem_ar_ready, the first al_valid can occur at cycle 2.
- req_ready depends on req_valid; requesters must not wait for ready before asserting valid.
- mem_ar_valid is not retracted once asserted, except by rst.
- Gaps in mem_r_valid are forwarded as gaps; framing is unaffected.
- Back-to-back requests: at least one DRAIN cycle occurs between bursts. The next accept can happen in the cycle after al_idle is seen in DRAIN.
- Simultaneous valid on both requesters: exactly one is accepted per accepting cycle, in alternating order while both are held.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values and the current burst abandoned. The memory and aligner are reset together with this block; stray r beats are not accepted.

## Test plan
- req0 addr 0x1000, bytes 16 → mem_ar_addr 0x1000, mem_ar_len 1, al_shamt 0; beat0 start=1/end=0, beat1 start=0/end=1; grant_id 0.
- req1 addr 0x1003, bytes 16 → mem_ar_addr 0x1000, mem_ar_len 2, al_shamt 3; al_end on the third beat only; busy until al_idle is seen in DRAIN.
- Both valid continuously from reset with bytes 8 → grants in order 0, 1, 0, 1; req_ready is never high for both.
- req0 bytes 0 → req_ready[0] high for 1 cycle, no mem_ar_valid, busy stays 0, and the next request is accepted the following cycle.
- mem_ar_ready low 5 cycles, then r beats arriving with 2-cycle gaps → mem_ar_addr/mem_ar_len stable while waiting; al_valid mirrors mem_r_valid; the counter advances only on valid beats.
- rst asserted in DATA after 1 of 3 beats → next cycle mem_r_ready 0, al_valid 0, busy 0; a new req0 is accepted afterwards and starts with al_start on its first beat.
